// File: rtl/inst_decode_block.sv
// Instruction decode stage: 32 x 32-bit register file, field split,
// immediate sign extension, destination selection, and the decode latch
// that presents operands to execute one cycle after the ID phase.
module inst_decode_block (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  ESTADO,
  input  logic [31:0] IR,
  input  logic [15:0] NPC,
  input  logic        WB_EN,
  input  logic [4:0]  WB_ADDR,
  input  logic [31:0] WB_DATA,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [31:0] IMM,
  output logic [15:0] NPC_ID,
  output logic [31:0] IR_ID,
  output logic [4:0]  RD,
  output logic        VALID
);

  localparam logic [2:0] PHASE_ID = 3'd1;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] imm_q, imm_d;
  logic [15:0] npc_q, npc_d;
  logic [31:0] ir_q, ir_d;
  logic [4:0]  rd_q, rd_d;
  logic        valid_q, valid_d;

  logic [5:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm_dec;
  logic [4:0]  rd_dec;
  logic        wr_en;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  // Split the instruction, build the immediate/destination, and read both
  // operands with same-edge writeback forwarded (R0 is never forwarded).
  always_comb begin
    opcode  = IR[31:26];
    rs1     = IR[25:21];
    rs2     = IR[20:16];
    imm_dec = {{16{IR[15]}}, IR[15:0]};
    rd_dec  = IR[20:16];
    case (opcode)
      OP_RTYPE: rd_dec = IR[15:11];
      OP_J: begin
        imm_dec = {{6{IR[25]}}, IR[25:0]};
        rd_dec  = 5'd0;
      end
      OP_JAL: begin
        imm_dec = {{6{IR[25]}}, IR[25:0]};
        rd_dec  = 5'd31;
      end
      default: ;
    endcase

    wr_en = WB_EN && (WB_ADDR != 5'd0);

    rs1_val = regs_q[rs1];
    if (rs1 == 5'd0)
      rs1_val = '0;
    else if (wr_en && (WB_ADDR == rs1))
      rs1_val = WB_DATA;

    rs2_val = regs_q[rs2];
    if (rs2 == 5'd0)
      rs2_val = '0;
    else if (wr_en && (WB_ADDR == rs2))
      rs2_val = WB_DATA;
  end

  // Next-state: register-file write in any phase, decode latch only in ID.
  always_comb begin
    regs_d = regs_q;
    if (wr_en)
      regs_d[WB_ADDR] = WB_DATA;

    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    npc_d   = npc_q;
    ir_d    = ir_q;
    rd_d    = rd_q;
    valid_d = 1'b0;
    if (ESTADO == PHASE_ID) begin
      a_d     = rs1_val;
      b_d     = rs2_val;
      imm_d   = imm_dec;
      npc_d   = NPC;
      ir_d    = IR;
      rd_d    = rd_dec;
      valid_d = 1'b1;
    end
  end

  // State registers; reset wins over any same-edge write or latch.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < 32; i++)
        regs_q[i] <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      npc_q   <= '0;
      ir_q    <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      npc_q   <= npc_d;
      ir_q    <= ir_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
    end
  end

  assign A      = a_q;
  assign B      = b_q;
  assign IMM    = imm_q;
  assign NPC_ID = npc_q;
  assign IR_ID  = ir_q;
  assign RD     = rd_q;
  assign VALID  = valid_q;

endmodule

// File: tb/tb_inst_decode_block.sv
// Randomized scoreboard bench for inst_decode_block: the stimulus process
// predicts the visible outputs after every edge from a behavioural model and
// queues them; a monitor pops and compares one entry per cycle.
module tb_inst_decode_block;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [15:0] npc;
    logic [31:0] ir;
    logic [4:0]  rd;
    logic        valid;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  ESTADO;
  logic [31:0] IR;
  logic [15:0] NPC;
  logic        WB_EN;
  logic [4:0]  WB_ADDR;
  logic [31:0] WB_DATA;
  logic [31:0] A, B, IMM, IR_ID;
  logic [15:0] NPC_ID;
  logic [4:0]  RD;
  logic        VALID;

  int checks = 0;
  int errors = 0;

  exp_t        expQ[$];
  exp_t        held;
  logic [31:0] modelRf [32];

  inst_decode_block dut (
    .CLK(CLK), .RST(RST), .ESTADO(ESTADO), .IR(IR), .NPC(NPC),
    .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
    .A(A), .B(B), .IMM(IMM), .NPC_ID(NPC_ID), .IR_ID(IR_ID),
    .RD(RD), .VALID(VALID)
  );

  // 10 ns clock
  always #5 CLK = ~CLK;

  // One comparison; every mismatch prints a FAIL line
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sign-extend an n-bit field using plain integer arithmetic
  function automatic logic [31:0] sext(input longint val, input int bits);
    longint v;
    v = val;
    if (v >= (64'sd1 <<< (bits - 1)))
      v = v - (64'sd1 <<< bits);
    return v[31:0];
  endfunction

  // Drive one cycle of inputs, predict the state after the coming edge,
  // queue it, then move to just after that edge
  task automatic applyStimulus(input logic rst, input logic [2:0] estado,
                               input logic [31:0] ir, input logic [15:0] npc,
                               input logic wbEn, input logic [4:0] wbAddr,
                               input logic [31:0] wbData);
    int op, r1, r2;
    RST = rst; ESTADO = estado; IR = ir; NPC = npc;
    WB_EN = wbEn; WB_ADDR = wbAddr; WB_DATA = wbData;
    if (!rst) begin
      for (int i = 0; i < 32; i++) modelRf[i] = 0;
      held = '{a: 0, b: 0, imm: 0, npc: 0, ir: 0, rd: 0, valid: 0};
    end else begin
      if (wbEn && wbAddr != 0) modelRf[wbAddr] = wbData;
      held.valid = (estado == 1);
      if (estado == 1) begin
        op = int'(ir[31:26]);
        r1 = int'(ir[25:21]);
        r2 = int'(ir[20:16]);
        held.a   = (r1 == 0) ? 32'd0 : modelRf[r1];
        held.b   = (r2 == 0) ? 32'd0 : modelRf[r2];
        held.npc = npc;
        held.ir  = ir;
        if (op == 0) begin
          held.imm = sext(longint'(ir[15:0]), 16);
          held.rd  = ir[15:11];
        end else if (op == 2 || op == 3) begin
          held.imm = sext(longint'(ir[25:0]), 26);
          held.rd  = (op == 3) ? 5'd31 : 5'd0;
        end else begin
          held.imm = sext(longint'(ir[15:0]), 16);
          held.rd  = ir[20:16];
        end
      end
    end
    expQ.push_back(held);
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compare DUT outputs to the queued prediction once per cycle
  initial begin
    exp_t e;
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard_empty: got no prediction, expected one");
      end else begin
        e = expQ.pop_front();
        checkOutput("VALID", 32'(VALID), 32'(e.valid));
        checkOutput("A", A, e.a);
        checkOutput("B", B, e.b);
        checkOutput("IMM", IMM, e.imm);
        checkOutput("NPC_ID", 32'(NPC_ID), 32'(e.npc));
        checkOutput("IR_ID", IR_ID, e.ir);
        checkOutput("RD", 32'(RD), 32'(e.rd));
      end
    end
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    logic [31:0] rir;
    logic [5:0]  rop;
    int          pick;
    $display("[TB] start");
    // reset for two cycles with a write and a latch pending
    applyStimulus(0, 1, 32'h00221800, 16'h1111, 1, 5, 32'hFFFFFFFF);
    applyStimulus(0, 1, 32'h00221800, 16'h1111, 1, 5, 32'hFFFFFFFF);
    // R5 must read back 0
    applyStimulus(1, 1, {6'h08, 5'd5, 5'd5, 16'h0000}, 16'h0004, 0, 0, 0);
    // R-type with held outputs through EX/MEM/WB
    applyStimulus(1, 0, 0, 0, 1, 1, 7);
    applyStimulus(1, 0, 0, 0, 1, 2, 9);
    applyStimulus(1, 1, 32'h00221800, 16'h0010, 0, 0, 0);
    applyStimulus(1, 2, 32'hDEADBEEF, 16'hFFFF, 0, 0, 0);
    applyStimulus(1, 3, 32'hDEADBEEF, 16'hFFFF, 0, 0, 0);
    applyStimulus(1, 4, 32'hDEADBEEF, 16'hFFFF, 0, 0, 0);
    // I-type negative immediate, then JAL
    applyStimulus(1, 1, 32'h2022FFFC, 16'h0014, 0, 0, 0);
    applyStimulus(1, 1, 32'h0E000010, 16'h0018, 0, 0, 0);
    // J with negative target, then unused phases 5..7 hold
    applyStimulus(1, 1, 32'h0A000000 | 32'h02000000, 16'h001C, 0, 0, 0);
    applyStimulus(1, 5, 0, 0, 1, 3, 32'hABCD);
    applyStimulus(1, 7, 0, 0, 0, 0, 0);
    // bypass on rs1 and later readback of R4
    applyStimulus(1, 0, 0, 0, 1, 4, 1);
    applyStimulus(1, 1, {6'h08, 5'd4, 5'd0, 16'h0000}, 16'h0020, 1, 4, 32'h55);
    applyStimulus(1, 1, {6'h08, 5'd0, 5'd4, 16'h0001}, 16'h0024, 0, 0, 0);
    // rs1 == rs2 under bypass
    applyStimulus(1, 1, {6'h00, 5'd6, 5'd6, 16'h3000}, 16'h0028, 1, 6, 32'hCAFE);
    // R0 writes discarded
    applyStimulus(1, 0, 0, 0, 1, 0, 32'h1234);
    applyStimulus(1, 1, {6'h08, 5'd0, 5'd0, 16'h0000}, 16'h002C, 1, 0, 32'h1234);
    // reset on a latch edge
    applyStimulus(0, 1, 32'h00221800, 16'h0030, 1, 1, 32'h77);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, {6'h08, 5'd1, 5'd3, 16'h8000}, 16'h0034, 0, 0, 0);
    // randomized traffic; small register indices to provoke bypass hits
    for (int n = 0; n < 400; n++) begin
      pick = $urandom_range(0, 3);
      rop  = (pick == 0) ? 6'h00 : (pick == 1) ? 6'h02 :
             (pick == 2) ? 6'h03 : 6'($urandom);
      rir = $urandom;
      rir[31:26] = rop;
      rir[25:21] = 5'($urandom_range(0, 7));
      rir[20:16] = 5'($urandom_range(0, 7));
      applyStimulus(($urandom_range(0, 39) != 0),
                    ($urandom_range(0, 1) == 1) ? 3'd1 : 3'($urandom),
                    rir, 16'($urandom), 1'($urandom),
                    5'($urandom_range(0, 7)), $urandom);
    end
    @(negedge CLK);
    #1;
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
